stack_seq: RTL

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_defs.sv | 19 +
 rtl/lat_counter.sv | 38 +++
 rtl/stack_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_defs.sv
// Shared definitions for the stack sequencer: op encoding, FSM states and
// the stack pointer value used after reset.
package stack_defs;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_PULL = 1'b1;

    // Stack pointer after reset, truncated/extended to the pointer width by users.
    localparam logic [7:0] SP_RESET = 8'hFD;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        PULL_ADDR,
        PULL_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/lat_counter.sv
// Read-latency down-counter: loaded with READ_LAT-1 when a read address is
// first presented, flags terminal count in the last cycle that address is held.
module lat_counter #(
    parameter int READ_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tc
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on a new address, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(READ_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/stack_seq.sv
// Stack sequencer: performs multi-byte push/pull bursts on a fixed stack page,
// highest byte first on push and byte 0 first on pull, with a wrapping pointer.
module stack_seq
    import stack_defs::*;
#(
    parameter int         DATA_W     = 8,
    parameter int         ADDR_W     = 16,
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter int         MAX_BYTES  = 4,
    parameter int         READ_LAT   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              op,
    input  logic [$clog2(MAX_BYTES+1)-1:0]    nbytes,
    input  logic [MAX_BYTES*DATA_W-1:0]       push_data,
    input  logic                              sp_load,
    input  logic [ADDR_W-9:0]                 sp_load_val,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_data_out,
    input  logic [DATA_W-1:0]                 mem_data_in,
    output logic                              mem_write_en,
    output logic                              busy,
    output logic                              done,
    output logic [MAX_BYTES*DATA_W-1:0]       pull_data,
    output logic [ADDR_W-9:0]                 sp,
    output logic                              stack_wrap
);

    localparam int SP_W  = ADDR_W - 8;
    localparam int NB_W  = $clog2(MAX_BYTES + 1);
    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [SP_W-1:0] SP_RST = SP_W'(SP_RESET);

    typedef logic [MAX_BYTES-1:0][DATA_W-1:0] bytes_t;

    state_t            state_q, state_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    bytes_t            data_q, data_d;
    bytes_t            pull_q, pull_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cnt_load;
    logic              cnt_tc;

    logic [SP_W-1:0]   sp_start;
    logic [SP_W-1:0]   sp_start_inc;
    logic [SP_W-1:0]   sp_inc;
    logic [SP_W-1:0]   sp_dec;
    logic [NB_W-1:0]   n_clamp;
    logic [IDX_W-1:0]  idx_first;
    logic [IDX_W-1:0]  idx_dec;
    logic [IDX_W-1:0]  idx_inc;
    logic              pull_last;
    bytes_t            push_bytes;

    // A load in the same cycle as a start supplies the burst's starting pointer.
    assign sp_start     = sp_load ? sp_load_val : sp_q;
    assign sp_start_inc = sp_start + 1'b1;
    assign sp_inc       = sp_q + 1'b1;
    assign sp_dec       = sp_q - 1'b1;
    assign n_clamp      = (nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : nbytes;
    assign idx_first    = IDX_W'(n_clamp - 1'b1);
    assign idx_dec      = idx_q - 1'b1;
    assign idx_inc      = idx_q + 1'b1;
    assign pull_last    = (nb_q == (NB_W'(idx_q) + NB_W'(1)));
    assign push_bytes   = push_data;

    lat_counter #(
        .READ_LAT (READ_LAT)
    ) u_lat_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .tc   (cnt_tc)
    );

    // Next-state and next-output logic; memory outputs are prepared one cycle ahead.
    always_comb begin
        state_d  = state_q;
        nb_d     = nb_q;
        idx_d    = idx_q;
        data_d   = data_q;
        pull_d   = pull_q;
        sp_d     = sp_q;
        wrap_d   = wrap_q;
        addr_d   = addr_q;
        dout_d   = '0;
        we_d     = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;

        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (sp_load) begin
                    sp_d   = sp_load_val;
                    wrap_d = 1'b0;
                end
                if (start) begin
                    nb_d   = n_clamp;
                    data_d = push_bytes;
                    if (n_clamp == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (op == OP_PUSH) begin
                        state_d = PUSH;
                        we_d    = 1'b1;
                        addr_d  = {STACK_PAGE, sp_start};
                        dout_d  = push_bytes[idx_first];
                        idx_d   = idx_first;
                    end else begin
                        state_d  = PULL_ADDR;
                        idx_d    = '0;
                        addr_d   = {STACK_PAGE, sp_start_inc};
                        sp_d     = sp_start_inc;
                        cnt_load = 1'b1;
                        if (sp_start == '1) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
            end

            PUSH: begin
                sp_d = sp_dec;
                if (sp_q == '0) begin
                    wrap_d = 1'b1;
                end
                if (idx_q != '0) begin
                    we_d   = 1'b1;
                    addr_d = {STACK_PAGE, sp_dec};
                    dout_d = data_q[idx_dec];
                    idx_d  = idx_dec;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    addr_d  = '0;
                end
            end

            PULL_ADDR, PULL_WAIT: begin
                if (cnt_tc) begin
                    pull_d[idx_q] = mem_data_in;
                    if (pull_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                    end else begin
                        state_d  = PULL_ADDR;
                        idx_d    = idx_inc;
                        addr_d   = {STACK_PAGE, sp_inc};
                        sp_d     = sp_inc;
                        cnt_load = 1'b1;
                        if (sp_q == '1) begin
                            wrap_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = PULL_WAIT;
                end
            end

            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end

            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state and registered outputs; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            nb_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            pull_q  <= '0;
            sp_q    <= SP_RST;
            wrap_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nb_q    <= nb_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            pull_q  <= pull_d;
            sp_q    <= sp_d;
            wrap_q  <= wrap_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_data_out = dout_q;
    assign mem_write_en = we_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pull_data    = pull_q;
    assign sp           = sp_q;
    assign stack_wrap   = wrap_q;

endmodule
